// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end:
//   INSTR_W        instruction / PC width
//   OPCODE_W       width of the opcode field (instr[15:12])
//   OP_*           opcode encodings decoded by the control unit
//   fetch_state_e  instruction-fetch FSM states
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;

    // Opcode encodings carried in instr[15:12]
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 4'd5;
    localparam logic [OPCODE_W-1:0] OP_NAND = 4'd6;
    localparam logic [OPCODE_W-1:0] OP_SW   = 4'd7;
    localparam logic [OPCODE_W-1:0] OP_LW   = 4'd8;
    localparam logic [OPCODE_W-1:0] OP_BLT  = 4'd9;

    // REQ     : a read is outstanding (or about to be issued right after reset)
    // HOLD    : an instruction is being presented to decode
    // DISCARD : a read made stale by a redirect is still outstanding
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// -----------------------------------------------------------------------------
// fetch_perf_counter
// Saturating event counter used to count instructions accepted by decode.
// Only instantiated by instr_fetch when INSTR_FETCH_PERF_EN is defined.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset, clears the count
//   inc_en  in   count one event this cycle
//   count   out  current count, sticks at all-ones
// -----------------------------------------------------------------------------
module fetch_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        // Saturate instead of wrapping so a long run never reads as a short one
        if (inc_en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Issues one word read at a time to instruction
// memory, presents the returned word to decode with a valid/ready handshake
// and follows branch redirects. Reads made stale by a redirect are tracked in
// the DISCARD state so their data is never presented.
//
// Build option: define INSTR_FETCH_PERF_EN to add the fetch_count output, a
// saturating count of instructions accepted by decode.
//
// Ports:
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_req        out  instruction memory read request
//   imem_addr       out  word address of the read, stable until imem_ack
//   imem_ack        in   imem_rdata valid this cycle (ignored when no request)
//   imem_rdata      in   instruction word returned by memory
//   redirect_valid  in   taken-branch redirect, highest priority
//   redirect_pc     in   redirect target address
//   instr_valid     out  instr / instr_pc / Opcode hold a valid instruction
//   instr_ready     in   decode accepts the instruction this cycle
//   instr           out  fetched instruction word
//   instr_pc        out  address of instr
//   Opcode          out  instr[15:12] for the control unit
//   fetch_count     out  accepted-instruction count (INSTR_FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req,
    output logic [INSTR_W-1:0]           imem_addr,
    input  logic                         imem_ack,
    input  logic [INSTR_W-1:0]           imem_rdata,
    input  logic                         redirect_valid,
    input  logic [INSTR_W-1:0]           redirect_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr,
    output logic [INSTR_W-1:0]           instr_pc,
    output logic [cpu_pkg::OPCODE_W-1:0] Opcode
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]                  fetch_count
`endif
);

    import cpu_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               imem_req_q, imem_req_d;
    logic [INSTR_W-1:0] imem_addr_q, imem_addr_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] instr_pc_q, instr_pc_d;

    // An ack only counts when a read is actually outstanding; acks that
    // arrive while no request is up (e.g. a late ack after reset) are noise.
    logic ack_seen;
    assign ack_seen = imem_ack && imem_req_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    if (!imem_req_q || ack_seen) begin
                        // Nothing left in flight: go straight to the target
                        imem_req_d  = 1'b1;
                        imem_addr_d = redirect_pc;
                        state_d     = REQ;
                    end else begin
                        // Read still in flight: keep the bus steady and
                        // throw its data away when it lands
                        state_d = DISCARD;
                    end
                end else if (!imem_req_q) begin
                    // First cycle after reset: raise the request
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                end else if (ack_seen) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;   // wraps modulo 2^INSTR_W
                    imem_req_d    = 1'b0;
                    state_d       = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = redirect_pc;
                    state_d       = REQ;
                end else if (instr_ready) begin
                    // pc already points past the presented instruction
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    imem_addr_d   = pc_q;
                    state_d       = REQ;
                end
            end

            DISCARD: begin
                instr_valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (ack_seen) begin
                        // Stale read finished on the same edge: fetch the
                        // newest target rather than waiting for another ack
                        imem_req_d  = 1'b1;
                        imem_addr_d = redirect_pc;
                        state_d     = REQ;
                    end
                end else if (ack_seen) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = REQ;
                end
            end

            default: begin
                state_d       = REQ;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign Opcode      = instr_q[INSTR_W-1 -: OPCODE_W];

`ifdef INSTR_FETCH_PERF_EN
    // A transfer completes only when decode takes the word and no redirect
    // overrides it on the same edge.
    logic accept;
    assign accept = (state_q == HOLD) && instr_ready && !redirect_valid;

    fetch_perf_counter #(
        .CNT_W (16)
    ) u_perf (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (accept),
        .count  (fetch_count)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios for reset, throughput, stall, redirects and PC wrap,
// followed by a randomized run against a transaction-level reference:
// presented instructions must follow program order (pc, pc+1, ...) restarted
// at every redirect target, carry the memory word of their address, and hold
// while decode stalls.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          N_RAND   = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [3:0]  Opcode;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    instr_fetch #(
        .INSTR_W  (16),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .Opcode         (Opcode)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Memory contents: an odd multiply plus xor is a bijection, so every
    // address holds a distinct word and a wrong address shows up as wrong data.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0, a} * 32'h0000_2F1B;
        return p[15:0] ^ 16'hC3A5;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,    0);
        check({tag, "_addr"},  imem_addr,   RESET_PC);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_instr"}, instr,       0);
        check({tag, "_ipc"},   instr_pc,    0);
        check({tag, "_op"},    Opcode,      0);
    endtask

    // Reference model state for the random run
    logic [15:0] exp_pc;
    logic [15:0] cur_word;
    logic [15:0] cur_pc;
    logic        prev_valid, prev_ready, prev_redir;
    logic        busy;
    logic [15:0] busy_addr;
    int          lat;
    int          gap;
    int          presented;
    int          accepted;
    logic        rdir, rdy;
    logic [15:0] tgt;
    logic [15:0] a;

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();

        // ------- back-to-back fetch, 1-cycle memory, ready high -------
        for (int k = 0; k < 3; k++) begin
            a = RESET_PC + 16'(k);
            check("t35_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, a});
            check("t35_idle", instr_valid, 0);
            imem_ack = 1'b1; imem_rdata = mem_word(a); instr_ready = 1'b1;
            cyc();
            check("t35_valid", {15'h0, instr_valid, instr_pc}, {15'h0, 1'b1, a});
            check("t35_instr", instr, mem_word(a));
            check("t35_noreq", imem_req, 0);
            $display("fetch pc=%h instr=%h", instr_pc, instr);
            imem_ack = 1'b0;
            cyc();
        end

        // ------- redirect coinciding with ack (pc 3 -> 5) -------
        check("t38_pre", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0003});
        redirect_valid = 1'b1; redirect_pc = 16'h0005;
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0003); instr_ready = 1'b0;
        cyc();
        check("t38_drop", instr_valid, 0);
        check("t38_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0005});

        // ------- stall with 0x8123 at 0005 -------
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h8123;
        cyc();
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;   // stray acks with no request
        for (int i = 0; i < 3; i++) begin
            check("t36_valid", instr_valid, 1);
            check("t36_instr", instr, 16'h8123);
            check("t36_op", Opcode, 4'h8);
            check("t36_ipc", instr_pc, 16'h0005);
            check("t36_noreq", imem_req, 0);
            cyc();
        end
        imem_ack = 1'b0; instr_ready = 1'b1;
        cyc();
        check("t36_done", instr_valid, 0);
        check("t36_next", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0006});

        // ------- redirect during outstanding read at 0x0010 -------
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0006); instr_ready = 1'b0;
        cyc();
        check("t37_at10", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0010});
        redirect_pc = 16'h0040; imem_ack = 1'b0;
        cyc();
        redirect_valid = 1'b0;
        check("t37_keep1", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0010});
        cyc();
        check("t37_keep2", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0010});
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0010);
        cyc();
        check("t37_drop", instr_valid, 0);
        check("t37_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0040});
        imem_rdata = mem_word(16'h0040); instr_ready = 1'b1;
        cyc();
        check("t37_valid", {15'h0, instr_valid, instr_pc}, {15'h0, 1'b1, 16'h0040});
        imem_ack = 1'b0;
        cyc();

        // ------- wrap from FFFF -------
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0041);
        cyc();
        check("t39_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'hFFFF});
        redirect_valid = 1'b0; imem_rdata = mem_word(16'hFFFF);
        cyc();
        check("t39_valid", {15'h0, instr_valid, instr_pc}, {15'h0, 1'b1, 16'hFFFF});
        imem_ack = 1'b0;
        cyc();
        check("t39_wrap", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});

        // ------- reset mid-read, late ack afterwards -------
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t40");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        cyc();
        check("t40_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, RESET_PC});
        check("t40_valid", instr_valid, 0);
        check("t40_instr", instr, 0);
        imem_ack = 1'b0;

        // ---------------- randomized run ----------------
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_pc = RESET_PC; cur_word = '0; cur_pc = '0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
        busy = 1'b0; busy_addr = '0; lat = 0; gap = 0;
        presented = 0; accepted = 0;

        for (int n = 0; n < N_RAND; n++) begin
            // --- observe the result of the previous edge ---
            if (prev_redir) begin
                check("r_redir_kill", instr_valid, 0);
            end else if (prev_valid && prev_ready) begin
                check("r_accept_clr", instr_valid, 0);
            end else if (prev_valid) begin
                check("r_hold_v", instr_valid, 1);
                check("r_hold_i", instr, cur_word);
                check("r_hold_pc", instr_pc, cur_pc);
            end
            if (instr_valid && !prev_valid) begin
                cur_pc   = exp_pc;
                cur_word = mem_word(exp_pc);
                check("r_pc", instr_pc, cur_pc);
                check("r_instr", instr, cur_word);
                check("r_op", Opcode, {28'h0, cur_word[15:12]});
                $display("fetch pc=%h instr=%h", instr_pc, instr);
                exp_pc = exp_pc + 16'd1;
                presented++;
                gap = 0;
            end else begin
                gap++;
            end
            if (gap > 80) begin
                check("r_stall", gap, 0);
                break;
            end

            // --- decode side and redirects ---
            rdy  = ($urandom_range(0, 9) < 7);
            rdir = ($urandom_range(0, 15) == 0);
            tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 1023));
            instr_ready    = rdy;
            redirect_valid = rdir;
            redirect_pc    = tgt;
            if (rdir) exp_pc = tgt;
            if (instr_valid && rdy && !rdir) accepted++;

            // --- memory responder ---
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            if (busy) begin
                check("r_req_stable", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, busy_addr});
            end else if (imem_req) begin
                busy      = 1'b1;
                busy_addr = imem_addr;
                lat       = $urandom_range(0, 2);
            end
            if (busy) begin
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(busy_addr);
                    busy       = 1'b0;
                end else begin
                    lat--;
                end
            end else if (!imem_req) begin
                imem_ack = ($urandom_range(0, 4) == 0);
            end

            prev_valid = instr_valid;
            prev_ready = rdy;
            prev_redir = rdir;
            cyc();
        end

        imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        check("r_progress", (presented >= 100), 1);
`ifdef INSTR_FETCH_PERF_EN
        @(negedge clk);
        check("r_fetch_count", fetch_count, 16'(accepted));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
